bsg_tie_strap_reg: RTL and testbench
====================================

Name: bsg_tie_strap_reg

Overview:
Parametrised successor to the fixed tie-high driver. Drives a width_p-bit constant strap vector that powers up to a parameterised pattern (all-ones by default, matching tie-high). Configuration logic can stage a new value in a shadow register using masked writes, then commit it to the output after a programmable settle delay. A sticky lock freezes the straps for the rest of the session. Sits between boot/config logic and blocks that consume quasi-static strap or tie-off inputs.

Parameters:
width_p, 64, width of the strap vector.
reset_val_p, {width_p{1'b1}}, value loaded into o and the shadow register on reset.
settle_p, 2, cycles from an accepted commit to o update; legal range is ≥1.

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous, active-high reset
v_i  input  1  shadow write valid
data_i  input  width_p  shadow write data
mask_i  input  width_p  per-bit write enable for data_i
ready_o  output  1  shadow write and commit accept
commit_i  input  1  request copy of shadow to o
lock_i  input  1  sticky lock request
o  output  width_p  registered strap output
shadow_o  output  width_p  current shadow register contents
pending_o  output  1  a commit is in flight
locked_o  output  1  lock has taken effect

Behaviour:
- Interface rules: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values: o = reset_val_p, shadow = reset_val_p, state = IDLE, pending_o = 0, locked_o = 0, counter = 0. After reset, ready_o = 1 provided lock_i = 0.
- ready_o = (state == IDLE) & ~locked_o & ~lock_i. This is combinational. Same-cycle lock_i blocks the write and the commit.
- States: IDLE and PENDING. pending_o = (state == PENDING).
- Write: on a clock edge where v_i & ready_o, shadow <= (shadow & ~mask_i) | (data_i & mask_i).
  - mask_i = 0 completes the handshake with no change to shadow.
  - v_i without ready_o is dropped; the sender must hold v_i.
- Commit acceptance: on an edge where commit_i & ready_o:
  - state -> PENDING;
  - counter <= settle_p-1;
  - the committed value is the shadow value after any same-edge write.
- PENDING behaviour, on each edge:
  - if counter == 0: o <= shadow and state -> IDLE;
  - otherwise counter decrements.
- Commit latency: a commit accepted at edge k updates o at edge k+settle_p. With settle_p = 1, o updates on the next edge.
- Shadow is frozen during PENDING because ready_o = 0.
- commit_i while in PENDING or while locked: ignored. No queueing.
- Lock: lock_i sampled high at any edge sets locked_o <= 1. Only reset_i clears it.
- Lock asserted during PENDING: the in-flight commit still completes.
- While locked: o, shadow, and state are otherwise frozen.
- Reset during PENDING: the commit is aborted and every state element returns to its reset value on that edge. reset_i has priority over all other inputs.
- Counter width: $clog2(settle_p+1) bits. No wrap-around is possible.
- o changes only at reset or on commit completion. It is glitch-free and driven straight from a flop.

Test Plan:
- Reset check: width_p = 64, hold reset_i 2 cycles, then release -> o = shadow_o = 64'hFFFF_FFFF_FFFF_FFFF, ready_o = 1, pending_o = 0, locked_o = 0.
- Masked write then commit: write data_i = 0, mask_i = 64'h0000_0000_0000_00FF, then commit at edge k (settle_p = 2) -> shadow_o = 64'hFFFF_FFFF_FFFF_FF00 immediately; pending_o = 1 and ready_o = 0 for edges k..k+1; o changes at edge k+2 only.
- Write and commit on the same cycle: v_i = 1, data_i = 0, mask_i = all-ones, commit_i = 1 -> o = 0 exactly settle_p edges later.
- Commit while pending: commit_i held high through PENDING with a different shadow intent -> exactly one update of o; a second commit is accepted only after pending_o falls.
- Lock: pulse lock_i during PENDING -> the pending commit completes; afterwards locked_o = 1 and ready_o = 0, and further v_i/commit_i leave o and shadow_o unchanged. lock_i together with v_i in IDLE -> the write is dropped.
- Reset mid-operation: assert reset_i one edge after a commit of 0 is accepted (settle_p = 3) -> o stays all-ones, pending_o = 0, shadow_o = all-ones, locked_o = 0.

Source files
------------

// File: rtl/bsg_tie_strap_reg.sv
// bsg_tie_strap_reg
//   Programmable strap/tie-off source. o powers up to reset_val_p (all-ones by
//   default, i.e. a tie-high). Config logic stages a new value in a shadow
//   register through masked writes, then commits it; o picks up the shadow
//   settle_p edges after the commit is accepted. A sticky lock freezes the
//   straps until the next reset.
//
// Ports
//   clk_i      clock
//   reset_i    synchronous active-high reset, highest priority
//   v_i        shadow write valid (dropped when ready_o is low)
//   data_i     shadow write data
//   mask_i     per-bit write enable for data_i
//   ready_o    write/commit accept (combinational)
//   commit_i   request copy of shadow to o
//   lock_i     sticky lock request
//   o          registered strap output
//   shadow_o   shadow register contents
//   pending_o  a commit is in flight
//   locked_o   lock has taken effect
module bsg_tie_strap_reg #(
  parameter int unsigned               width_p     = 64,
  parameter logic [width_p-1:0]        reset_val_p = '1,
  parameter int unsigned               settle_p    = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic [width_p-1:0] mask_i,
  output logic               ready_o,
  input  logic               commit_i,
  input  logic               lock_i,
  output logic [width_p-1:0] o,
  output logic [width_p-1:0] shadow_o,
  output logic               pending_o,
  output logic               locked_o
);

  localparam int unsigned cnt_w_lp = $clog2(settle_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_init_lp = cnt_w_lp'(settle_p - 1);

  typedef enum logic {
    e_idle,
    e_pending
  } state_e;

  state_e               state_q, state_d;
  logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
  logic [width_p-1:0]   o_q, o_d;
  logic [width_p-1:0]   shadow_q, shadow_d;
  logic                 locked_q, locked_d;
  logic                 ready;

  // Same-cycle lock_i already blocks writes and commits.
  assign ready = (state_q == e_idle) & ~locked_q & ~lock_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    o_d      = o_q;
    shadow_d = shadow_q;
    locked_d = locked_q;

    if (v_i & ready)
      shadow_d = (shadow_q & ~mask_i) | (data_i & mask_i);

    if (commit_i & ready) begin
      state_d = e_pending;
      cnt_d   = cnt_init_lp;
    end

    // Shadow cannot change while pending (ready is low), so copying the
    // current shadow yields the value captured at commit acceptance.
    if (state_q == e_pending) begin
      if (cnt_q == '0) begin
        o_d     = shadow_q;
        state_d = e_idle;
      end else begin
        cnt_d = cnt_q - cnt_w_lp'(1);
      end
    end

    if (lock_i)
      locked_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      cnt_q    <= '0;
      o_q      <= reset_val_p;
      shadow_q <= reset_val_p;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      o_q      <= o_d;
      shadow_q <= shadow_d;
      locked_q <= locked_d;
    end
  end

  assign ready_o   = ready;
  assign o         = o_q;
  assign shadow_o  = shadow_q;
  assign pending_o = (state_q == e_pending);
  assign locked_o  = locked_q;

endmodule

// File: tb/tb_bsg_tie_strap_reg.sv
// Bench for bsg_tie_strap_reg: two instances (settle 2 and settle 3) share the
// same stimulus; a cycle-count based model predicts both every cycle, and
// directed literal expectations pin the model's behaviour.
module tb_bsg_tie_strap_reg;

  localparam logic [63:0] ONES = '1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v = 1'b0;
  logic [63:0] d = '0;
  logic [63:0] m = '0;
  logic        c = 1'b0;
  logic        l = 1'b0;

  logic [63:0] o_a [2];
  logic [63:0] sh_a [2];
  logic        rdy_a [2];
  logic        pend_a [2];
  logic        lck_a [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_tie_strap_reg #(.width_p(64), .settle_p(2)) u2 (
    .clk_i(clk), .reset_i(rst), .v_i(v), .data_i(d), .mask_i(m),
    .ready_o(rdy_a[0]), .commit_i(c), .lock_i(l), .o(o_a[0]),
    .shadow_o(sh_a[0]), .pending_o(pend_a[0]), .locked_o(lck_a[0]));

  bsg_tie_strap_reg #(.width_p(64), .settle_p(3)) u3 (
    .clk_i(clk), .reset_i(rst), .v_i(v), .data_i(d), .mask_i(m),
    .ready_o(rdy_a[1]), .commit_i(c), .lock_i(l), .o(o_a[1]),
    .shadow_o(sh_a[1]), .pending_o(pend_a[1]), .locked_o(lck_a[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: tracks the due cycle of an in-flight commit rather than a countdown.
  int          settle [2] = '{2, 3};
  int          cyc = 0;
  bit          started = 0;
  logic [63:0] m_o [2];
  logic [63:0] m_sh [2];
  logic [63:0] m_cv [2];
  bit          m_busy [2];
  bit          m_lock [2];
  int          m_due [2];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_o[i] = ONES; m_sh[i] = ONES; m_busy[i] = 0; m_lock[i] = 0;
      end else if (started) begin
        bit accept;
        accept = !m_busy[i] && !m_lock[i] && !l;
        if (m_busy[i] && cyc == m_due[i]) begin
          m_o[i] = m_cv[i];
          m_busy[i] = 0;
        end
        if (accept && v) m_sh[i] = (m_sh[i] & ~m) | (d & m);
        if (accept && c) begin
          m_busy[i] = 1;
          m_due[i]  = cyc + settle[i];
          m_cv[i]   = m_sh[i];
        end
        if (l) m_lock[i] = 1;
      end
    end
    if (rst) started = 1;
    #1;
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("o[%0d]", i), o_a[i], m_o[i]);
        chk($sformatf("shadow[%0d]", i), sh_a[i], m_sh[i]);
        chk($sformatf("pending[%0d]", i), 64'(pend_a[i]), 64'(m_busy[i]));
        chk($sformatf("locked[%0d]", i), 64'(lck_a[i]), 64'(m_lock[i]));
        chk($sformatf("ready[%0d]", i), 64'(rdy_a[i]),
            64'(!m_busy[i] && !m_lock[i] && !l));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    v = 0; d = '0; m = '0; c = 0; l = 0;
  endtask

  initial begin
    @(negedge clk);
    // Reset
    rst = 1; tick(); tick(); rst = 0;
    chk("rst_o", o_a[0], ONES);
    chk("rst_shadow", sh_a[0], ONES);
    chk("rst_ready", 64'(rdy_a[0]), 64'd1);
    chk("rst_pending", 64'(pend_a[0]), 64'd0);
    chk("rst_locked", 64'(lck_a[0]), 64'd0);

    // Masked write then commit
    v = 1; d = '0; m = 64'h0000_0000_0000_00FF; tick(); idle();
    chk("mw_shadow", sh_a[0], 64'hFFFF_FFFF_FFFF_FF00);
    chk("mw_o_unchanged", o_a[0], ONES);
    c = 1; tick(); idle();                       // edge k
    chk("mw_pend_k", 64'(pend_a[0]), 64'd1);
    chk("mw_ready_k", 64'(rdy_a[0]), 64'd0);
    chk("mw_o_k", o_a[0], ONES);
    tick();                                      // edge k+1
    chk("mw_pend_k1", 64'(pend_a[0]), 64'd1);
    chk("mw_o_k1", o_a[0], ONES);
    tick();                                      // edge k+2
    chk("mw_o_k2", o_a[0], 64'hFFFF_FFFF_FFFF_FF00);
    chk("mw_pend_k2", 64'(pend_a[0]), 64'd0);
    chk("mw_ready_k2", 64'(rdy_a[0]), 64'd1);
    chk("mw_o3_k2", o_a[1], ONES);
    tick();
    chk("mw_o3_k3", o_a[1], 64'hFFFF_FFFF_FFFF_FF00);

    // Write and commit on the same cycle
    v = 1; d = '0; m = ONES; c = 1; tick(); idle();
    tick();
    chk("wc_o_k1", o_a[0], 64'hFFFF_FFFF_FFFF_FF00);
    tick();
    chk("wc_o_k2", o_a[0], 64'd0);
    tick();
    chk("wc_o3_k3", o_a[1], 64'd0);

    // Commit held through PENDING with a different shadow intent
    v = 1; d = ONES; m = ONES; tick(); idle();
    c = 1; tick();                               // edge k
    v = 1; d = 64'h5555_5555_5555_5555; m = ONES;
    tick(); tick();                              // edges k+1, k+2
    chk("cp_o_k2", o_a[0], ONES);
    chk("cp_pend_k2", 64'(pend_a[0]), 64'd0);
    chk("cp_shadow_k2", sh_a[0], ONES);
    tick(); idle();                              // edge k+3: second commit
    chk("cp_pend_k3", 64'(pend_a[0]), 64'd1);
    chk("cp_shadow_k3", sh_a[0], 64'h5555_5555_5555_5555);
    tick();
    chk("cp_o_k4", o_a[0], ONES);
    tick();
    chk("cp_o_k5", o_a[0], 64'h5555_5555_5555_5555);
    tick(); tick();

    // Reset one edge after a commit of 0 is accepted (settle 3 instance)
    v = 1; d = '0; m = ONES; c = 1; tick(); idle();
    rst = 1; tick(); rst = 0;
    chk("rm_o", o_a[1], ONES);
    chk("rm_pend", 64'(pend_a[1]), 64'd0);
    chk("rm_shadow", sh_a[1], ONES);
    chk("rm_locked", 64'(lck_a[1]), 64'd0);
    tick(); tick(); tick(); tick();
    chk("rm_o_late", o_a[1], ONES);

    // Lock pulsed during PENDING
    v = 1; d = '0; m = ONES; c = 1; tick(); idle();
    l = 1; tick(); l = 0;
    tick();
    chk("lk_o", o_a[0], 64'd0);
    chk("lk_locked", 64'(lck_a[0]), 64'd1);
    chk("lk_ready", 64'(rdy_a[0]), 64'd0);
    v = 1; d = ONES; m = ONES; c = 1;
    tick(); tick(); tick(); tick(); idle();
    chk("lk_o_frozen", o_a[0], 64'd0);
    chk("lk_shadow_frozen", sh_a[0], 64'd0);
    chk("lk_o3", o_a[1], 64'd0);

    // Lock with a write in IDLE drops the write
    rst = 1; tick(); rst = 0;
    l = 1; v = 1; d = 64'h0123_4567_89AB_CDEF; m = ONES; tick(); idle();
    chk("lw_shadow", sh_a[0], ONES);
    chk("lw_locked", 64'(lck_a[0]), 64'd1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
